// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and defaults for the CPU/debug memory arbiter.
package mem_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic {CPU, DBG} owner_t;
    localparam int DEF_TMO = 16;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester-side and memory-side signals of the arbiter.
interface mem_arbiter_if #(parameter int DW = 32, parameter int AW = 32);
    logic          cpu_req, cpu_we, cpu_ack, cpu_err;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          dbg_req, dbg_we, dbg_ack, dbg_err;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic [DW-1:0] rdata;
    logic          mem_req, mem_we, mem_ack;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  mem_ack, mem_rdata,
        output cpu_ack, cpu_err, dbg_ack, dbg_err, rdata,
        output mem_req, mem_we, mem_addr, mem_wdata
    );
    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output mem_ack, mem_rdata,
        input  cpu_ack, cpu_err, dbg_ack, dbg_err, rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_tmo_cnt.sv
// mem_tmo_cnt: memory-ack timeout counter; expired once TMO-1 cycles have elapsed.
module mem_tmo_cnt #(parameter int TMO = 16) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int W = $clog2(TMO);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en && !expired) cnt <= cnt + 1'b1;
    assign expired = cnt == W'(TMO - 1);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter between a CPU and a debug loader for one shared memory,
// with a per-access ack timeout.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int DW  = 32,
    parameter int AW  = 32,
    parameter int TMO = DEF_TMO
) (
    input logic clk,
    input logic reset_n,
    mem_arbiter_if.master bus
);
    state_t        state;
    owner_t        owner, last, win;
    logic          err_q, mem_we_q, expired;
    logic [DW-1:0] rdata_q, mem_wdata_q;
    logic [AW-1:0] mem_addr_q;
    // CPU wins unless DBG is also asking and CPU had the previous grant
    assign win = (bus.cpu_req && (!bus.dbg_req || last == DBG)) ? CPU : DBG;
    mem_tmo_cnt #(.TMO(TMO)) u_tmo (
        .clk(clk), .reset_n(reset_n), .clr(state != BUSY),
        .en(state == BUSY && !bus.mem_ack), .expired(expired)
    );
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state       <= IDLE;
            owner       <= CPU;
            last        <= DBG;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state)
                IDLE: if (bus.cpu_req || bus.dbg_req) begin
                    owner       <= win;
                    last        <= win;
                    mem_we_q    <= win == CPU ? bus.cpu_we : bus.dbg_we;
                    mem_addr_q  <= win == CPU ? bus.cpu_addr : bus.dbg_addr;
                    mem_wdata_q <= win == CPU ? bus.cpu_wdata : bus.dbg_wdata;
                    state       <= BUSY;
                end
                BUSY: if (bus.mem_ack) begin
                    rdata_q <= mem_we_q ? '0 : bus.mem_rdata;
                    err_q   <= 1'b0;
                    state   <= DONE;
                end else if (expired) begin
                    rdata_q <= '0;
                    err_q   <= 1'b1;
                    state   <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    assign bus.mem_req   = state == BUSY;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rdata     = rdata_q;
    assign bus.cpu_ack   = state == DONE && owner == CPU;
    assign bus.dbg_ack   = state == DONE && owner == DBG;
    assign bus.cpu_err   = bus.cpu_ack && err_q;
    assign bus.dbg_err   = bus.dbg_ack && err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven single-access vectors plus hand sequences for
// round-robin alternation, reset mid-access and spurious memory acks.
module tb_mem_arbiter;
    localparam int TMO = 16;
    logic clk = 1'b0, reset_n = 1'b0;
    int errors = 0, checks = 0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.DW(32), .AW(32)) bus ();
    mem_arbiter #(.DW(32), .AW(32), .TMO(TMO)) dut (.clk(clk), .reset_n(reset_n), .bus(bus.master));

    typedef struct {
        logic cr, dr, cw, dw;
        logic [31:0] ca, da, cwd, dwd;
        int dly;
        logic [31:0] mrd;
        logic ecpu;
        logic [31:0] eaddr, ewd;
        logic ewe, eerr;
        logic [31:0] erd;
        int ebusy;
    } vec_t;
    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.cpu_req = 0; bus.dbg_req = 0; bus.cpu_we = 0; bus.dbg_we = 0;
        bus.cpu_addr = 0; bus.dbg_addr = 0; bus.cpu_wdata = 0; bus.dbg_wdata = 0;
        bus.mem_ack = 0; bus.mem_rdata = 0;
    endtask

    task automatic wait_req(output int c);
        c = 0;
        @(negedge clk);
        while (!bus.mem_req && c < 4) begin
            @(negedge clk);
            c++;
        end
    endtask

    task automatic run(input vec_t v);
        int c, n;
        bus.cpu_req = v.cr; bus.dbg_req = v.dr; bus.cpu_we = v.cw; bus.dbg_we = v.dw;
        bus.cpu_addr = v.ca; bus.dbg_addr = v.da; bus.cpu_wdata = v.cwd; bus.dbg_wdata = v.dwd;
        bus.mem_rdata = v.mrd; bus.mem_ack = 0;
        wait_req(c);
        check("grant_latency", c, 0);
        check("mem_we", bus.mem_we, v.ewe);
        check("mem_wdata", bus.mem_wdata, v.ewd);
        n = 0;
        while (bus.mem_req && n < TMO + 2) begin
            check("mem_addr", bus.mem_addr, v.eaddr);
            bus.mem_ack = (n == v.dly);
            @(negedge clk);
            n++;
        end
        bus.mem_ack = 0;
        check("busy_cycles", n, v.ebusy);
        check("cpu_ack", bus.cpu_ack, v.ecpu);
        check("dbg_ack", bus.dbg_ack, !v.ecpu);
        check("cpu_err", bus.cpu_err, v.ecpu ? v.eerr : 1'b0);
        check("dbg_err", bus.dbg_err, v.ecpu ? 1'b0 : v.eerr);
        check("rdata", bus.rdata, v.erd);
        bus.cpu_req = 0; bus.dbg_req = 0;
        @(negedge clk);
        check("ack_after_done", {bus.cpu_ack, bus.dbg_ack, bus.mem_req}, 0);
    endtask

    initial begin
        int c, acks, reqs;
        // cr dr cw dw ca da cwd dwd dly mrd | ecpu eaddr ewd ewe eerr erd ebusy
        vecs[0] = '{1, 0, 0, 0, 32'h40, 0, 0, 0, 2, 32'hDEADBEEF, 1, 32'h40, 0, 0, 0, 32'hDEADBEEF, 3};
        vecs[1] = '{0, 1, 0, 1, 0, 32'h100, 0, 32'h12345678, -1, 32'h55, 0, 32'h100, 32'h12345678, 1, 1, 0, 16};
        vecs[2] = '{1, 1, 0, 0, 32'h10, 32'h20, 0, 0, 0, 32'hA5A5A5A5, 1, 32'h10, 0, 0, 0, 32'hA5A5A5A5, 1};
        vecs[3] = '{1, 1, 0, 0, 32'h10, 32'h20, 0, 0, 15, 32'h0BADF00D, 0, 32'h20, 0, 0, 0, 32'h0BADF00D, 16};
        vecs[4] = '{1, 0, 1, 0, 32'h44, 0, 32'hCAFEF00D, 0, 1, 32'hFFFFFFFF, 1, 32'h44, 32'hCAFEF00D, 1, 0, 0, 2};
        vecs[5] = '{0, 1, 0, 0, 0, 32'h200, 0, 0, 3, 32'h11223344, 0, 32'h200, 0, 0, 0, 32'h11223344, 4};
        vecs[6] = '{1, 0, 0, 0, 32'h80, 0, 0, 0, -1, 32'h99, 1, 32'h80, 0, 0, 1, 0, 16};
        idle_inputs();
        repeat (2) @(negedge clk);
        check("rst_state", {bus.mem_req, bus.mem_we, bus.cpu_ack, bus.dbg_ack, bus.cpu_err, bus.dbg_err}, 0);
        check("rst_addr", bus.mem_addr, 0);
        check("rst_wdata", bus.mem_wdata, 0);
        check("rst_rdata", bus.rdata, 0);
        reset_n = 1;
        // both requesters held from reset: CPU, DBG, CPU, DBG
        bus.cpu_req = 1; bus.dbg_req = 1; bus.cpu_addr = 32'h10; bus.dbg_addr = 32'h20;
        bus.mem_ack = 1; bus.mem_rdata = 32'h1;
        for (int i = 0; i < 4; i++) begin
            wait_req(c);
            check("rr_mem_req", bus.mem_req, 1);
            check("rr_mem_addr", bus.mem_addr, i % 2 == 0 ? 32'h10 : 32'h20);
            @(negedge clk);
            check("rr_cpu_ack", bus.cpu_ack, i % 2 == 0);
            check("rr_dbg_ack", bus.dbg_ack, i % 2 == 1);
        end
        idle_inputs();
        @(negedge clk);
        foreach (vecs[i]) run(vecs[i]);
        // reset while BUSY: access abandoned, held request re-granted
        bus.cpu_req = 1; bus.cpu_addr = 32'h300;
        wait_req(c);
        check("rb_busy", bus.mem_req, 1);
        reset_n = 0;
        #1;
        check("rb_mem_req_drop", bus.mem_req, 0);
        check("rb_addr_clear", bus.mem_addr, 0);
        @(negedge clk);
        check("rb_no_ack", {bus.cpu_ack, bus.dbg_ack}, 0);
        reset_n = 1;
        @(negedge clk);
        check("rb_regrant", bus.mem_req, 1);
        check("rb_regrant_addr", bus.mem_addr, 32'h300);
        bus.mem_ack = 1; bus.mem_rdata = 32'h3C3C3C3C;
        @(negedge clk);
        check("rb_cpu_ack", bus.cpu_ack, 1);
        check("rb_rdata", bus.rdata, 32'h3C3C3C3C);
        idle_inputs();
        @(negedge clk);
        // spurious mem_ack in IDLE and DONE
        bus.mem_ack = 1; bus.mem_rdata = 32'h77;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("sp_idle", {bus.mem_req, bus.cpu_ack, bus.dbg_ack}, 0);
        end
        bus.cpu_req = 1; bus.cpu_addr = 32'h400;
        acks = 0; reqs = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            reqs += int'(bus.mem_req);
            if (bus.cpu_ack || bus.dbg_ack) begin
                acks++;
                check("sp_rdata", bus.rdata, 32'h77);
                bus.cpu_req = 0;
            end
        end
        check("sp_ack_count", acks, 1);
        check("sp_req_cycles", reqs, 1);
        idle_inputs();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
